// File: rtl/param_beamform_square_accum.sv
// Beamformer: per-beam channel sums, exact squares, windowed power.
// Ports: clk_i/rst_i, valid_i+data_i samples, use_i/invert_i shadow
//   config (cfg_update_i, cfg_pending_o), sum_o/sq_o/sq_valid_o per
//   beat after 3 stages, acc_o/acc_valid_o once per ACCLEN beats.
module param_beamform_square_accum #(
  parameter int NBITS  = 5,
  parameter int NSAMP  = 4,
  parameter int NCHAN  = 8,
  parameter int NBEAMS = 2,
  parameter int ACCLEN = 4,
  localparam int SW   = NBITS + 1 + $clog2(NCHAN),
  localparam int SQW  = 2 * SW - 2,
  localparam int ACCW = SQW + $clog2(NSAMP * ACCLEN)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 valid_i,
  input  logic [NBEAMS*NCHAN*NSAMP*NBITS-1:0]  data_i,
  input  logic [NBEAMS*NCHAN-1:0]              use_i,
  input  logic [NBEAMS*NCHAN-1:0]              invert_i,
  input  logic                                 cfg_update_i,
  output logic                                 cfg_pending_o,
  output logic [NBEAMS*NSAMP*SW-1:0]           sum_o,
  output logic [NBEAMS*NSAMP*SQW-1:0]          sq_o,
  output logic                                 sq_valid_o,
  output logic [NBEAMS*ACCW-1:0]               acc_o,
  output logic                                 acc_valid_o
);
  localparam int VW   = NBITS + 1;
  localparam int NCH  = NBEAMS * NCHAN;
  localparam int NSM  = NBEAMS * NSAMP;
  localparam int NTOT = NCH * NSAMP;
  localparam int CW   = $clog2(ACCLEN);

  logic [NCH-1:0] useAct, invAct;
  logic [NCH-1:0] useShd, invShd;
  logic [NCH-1:0] useEff, invEff;
  logic           cfgPend;
  logic [CW-1:0]  winCnt;
  logic           firstIn, lastIn, xfer;

  assign firstIn = (winCnt == '0);
  assign lastIn  = (winCnt == CW'(ACCLEN - 1));
  // A pending shadow takes effect on the very beat that opens a window.
  assign xfer    = valid_i && firstIn && cfgPend;
  assign useEff  = xfer ? useShd : useAct;
  assign invEff  = xfer ? invShd : invAct;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      useAct  <= '1;
      invAct  <= '0;
      useShd  <= '1;
      invShd  <= '0;
      cfgPend <= 1'b0;
    end else begin
      if (xfer) begin
        useAct <= useShd;
        invAct <= invShd;
      end
      if (cfg_update_i) begin
        useShd <= use_i;
        invShd <= invert_i;
      end
      if (cfg_update_i)
        cfgPend <= 1'b1;
      else if (xfer)
        cfgPend <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      winCnt <= '0;
    else if (valid_i)
      winCnt <= lastIn ? '0 : winCnt + 1'b1;
  end

  // 2*c-(2^N-1) == 2*(c-2^(N-1))+1: flip the MSB for the
  // two's-complement offset and append a constant 1 LSB.
  logic [NBITS-1:0]          cw;
  logic [NTOT-1:0][VW-1:0]   vIn;

  always_comb begin
    vIn = '0;
    cw  = '0;
    for (int i = 0; i < NTOT; i++) begin
      cw = data_i[i*NBITS +: NBITS] ^ {NBITS{invEff[i/NSAMP]}};
      if (useEff[i/NSAMP])
        vIn[i] = {~cw[NBITS-1], cw[NBITS-2:0], 1'b1};
    end
  end

  logic                    s1Vld, s1First, s1Last;
  logic [NTOT-1:0][VW-1:0] s1V;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1Vld   <= 1'b0;
      s1First <= 1'b0;
      s1Last  <= 1'b0;
      s1V     <= '0;
    end else begin
      s1Vld   <= valid_i;
      s1First <= valid_i && firstIn;
      s1Last  <= valid_i && lastIn;
      if (valid_i)
        s1V <= vIn;
    end
  end

  logic [NSM-1:0][SW-1:0] sumC;
  logic [VW-1:0]          vs;

  always_comb begin
    sumC = '0;
    vs   = '0;
    for (int b = 0; b < NBEAMS; b++)
      for (int s = 0; s < NSAMP; s++)
        for (int c = 0; c < NCHAN; c++) begin
          vs = s1V[s + NSAMP * (c + NCHAN * b)];
          sumC[b*NSAMP+s] = sumC[b*NSAMP+s]
                          + {{(SW-VW){vs[VW-1]}}, vs};
        end
  end

  logic                   s2Vld, s2First, s2Last;
  logic [NSM-1:0][SW-1:0] s2Sum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2Vld   <= 1'b0;
      s2First <= 1'b0;
      s2Last  <= 1'b0;
      s2Sum   <= '0;
    end else begin
      s2Vld   <= s1Vld;
      s2First <= s1First;
      s2Last  <= s1Last;
      if (s1Vld)
        s2Sum <= sumC;
    end
  end

  // |S| < 2^(SW-1), so squaring the magnitude fills SQW exactly.
  logic [NSM-1:0][SW-2:0]  mag;
  logic [NSM-1:0][SQW-1:0] sqC;

  always_comb begin
    mag = '0;
    sqC = '0;
    for (int i = 0; i < NSM; i++) begin
      mag[i] = s2Sum[i][SW-1] ? (SW-1)'(-s2Sum[i])
                              : s2Sum[i][SW-2:0];
      sqC[i] = SQW'(mag[i]) * SQW'(mag[i]);
    end
  end

  logic                    s3Vld, s3First, s3Last;
  logic [NSM-1:0][SW-1:0]  s3Sum;
  logic [NSM-1:0][SQW-1:0] s3Sq;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s3Vld   <= 1'b0;
      s3First <= 1'b0;
      s3Last  <= 1'b0;
      s3Sum   <= '0;
      s3Sq    <= '0;
    end else begin
      s3Vld   <= s2Vld;
      s3First <= s2First;
      s3Last  <= s2Last;
      if (s2Vld) begin
        s3Sum <= s2Sum;
        s3Sq  <= sqC;
      end
    end
  end

  logic [NBEAMS-1:0][ACCW-1:0] powC, accNext, acc, accOut;
  logic                        accVld;

  always_comb begin
    powC    = '0;
    accNext = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      for (int s = 0; s < NSAMP; s++)
        powC[b] = powC[b] + ACCW'(s3Sq[b*NSAMP+s]);
      accNext[b] = (s3First ? '0 : acc[b]) + powC[b];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc    <= '0;
      accOut <= '0;
      accVld <= 1'b0;
    end else begin
      accVld <= s3Vld && s3Last;
      if (s3Vld) begin
        acc <= accNext;
        if (s3Last)
          accOut <= accNext;
      end
    end
  end

  assign cfg_pending_o = cfgPend;
  assign sum_o         = s3Sum;
  assign sq_o          = s3Sq;
  assign sq_valid_o    = s3Vld;
  assign acc_o         = accOut;
  assign acc_valid_o   = accVld;

endmodule

// File: tb/tb_param_beamform_square_accum.sv
// Bench for param_beamform_square_accum: directed table windows,
// corner sequences and random beats against a beat-level model.
module tb_param_beamform_square_accum;
  localparam int NBITS = 5, NSAMP = 4, NCHAN = 8;
  localparam int NBEAMS = 2, ACCLEN = 4;
  localparam int SW = 9, SQW = 16, ACCW = 20;
  localparam int NB = NBEAMS * NCHAN;
  localparam int NS = NBEAMS * NSAMP;
  localparam int NT = NB * NSAMP;

  logic clk = 0, rst = 0, valid = 0, cfgUpd = 0;
  logic [NT*NBITS-1:0] data = '0;
  logic [NB-1:0] useV = '1, invV = '0;
  logic cfgPend, sqValid, accValid;
  logic [NS*SW-1:0] sumO;
  logic [NS*SQW-1:0] sqO;
  logic [NBEAMS*ACCW-1:0] accO;

  always #5 clk = ~clk;

  param_beamform_square_accum dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data),
    .use_i(useV), .invert_i(invV), .cfg_update_i(cfgUpd),
    .cfg_pending_o(cfgPend), .sum_o(sumO), .sq_o(sqO),
    .sq_valid_o(sqValid), .acc_o(accO), .acc_valid_o(accValid));

  int nCmp = 0, nErr = 0, accPulses = 0;

  bit [NB-1:0] mUseA, mInvA, mUseS, mInvS;
  bit mPend;
  int mCnt;
  longint mAcc[NBEAMS];
  bit hVld[4], hLast[4];
  int hSum[4][NS], hSq[4][NS], hTot[4][NBEAMS];
  int eSum[NS], eSq[NS], eAcc[NBEAMS];
  bit eSqV, eAccV;

  task automatic chk(input string n, input longint act,
                     input longint exp);
    nCmp++;
    if (act != exp) begin
      nErr++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  function automatic longint sumAt(input int i);
    return longint'($signed(sumO[i*SW +: SW]));
  endfunction

  function automatic longint sqAt(input int i);
    return longint'(sqO[i*SQW +: SQW]);
  endfunction

  function automatic longint accAt(input int b);
    return longint'(accO[b*ACCW +: ACCW]);
  endfunction

  task automatic modelReset();
    mUseA = '1; mInvA = '0; mUseS = '1; mInvS = '0;
    mPend = 0; mCnt = 0; eSqV = 0; eAccV = 0;
    for (int k = 0; k < 4; k++) begin
      hVld[k] = 0; hLast[k] = 0;
    end
    for (int i = 0; i < NS; i++) begin
      eSum[i] = 0; eSq[i] = 0;
    end
    for (int b = 0; b < NBEAMS; b++) begin
      eAcc[b] = 0; mAcc[b] = 0;
    end
  endtask

  task automatic checkAll(input string t);
    chk({t, ".sqv"}, longint'(sqValid), longint'(eSqV));
    chk({t, ".accv"}, longint'(accValid), longint'(eAccV));
    chk({t, ".pend"}, longint'(cfgPend), longint'(mPend));
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("%s.sum%0d", t, i), sumAt(i), eSum[i]);
      chk($sformatf("%s.sq%0d", t, i), sqAt(i), eSq[i]);
    end
    for (int b = 0; b < NBEAMS; b++)
      chk($sformatf("%s.acc%0d", t, b), accAt(b), eAcc[b]);
  endtask

  // One clock: drive inputs, predict the beat, check after the edge.
  task automatic cycle(input bit v, input bit upd);
    bit [NB-1:0] u, iv;
    int c, a, p;
    valid = v; cfgUpd = upd;
    u = mUseA; iv = mInvA;
    if (v && mCnt == 0 && mPend) begin
      u = mUseS; iv = mInvS;
      mUseA = mUseS; mInvA = mInvS; mPend = 0;
    end
    if (upd) begin
      mUseS = useV; mInvS = invV; mPend = 1;
    end
    for (int k = 3; k > 0; k--) begin
      hVld[k] = hVld[k-1]; hLast[k] = hLast[k-1];
      for (int i = 0; i < NS; i++) begin
        hSum[k][i] = hSum[k-1][i]; hSq[k][i] = hSq[k-1][i];
      end
      for (int b = 0; b < NBEAMS; b++) hTot[k][b] = hTot[k-1][b];
    end
    hVld[0] = v; hLast[0] = 0;
    if (v) begin
      for (int b = 0; b < NBEAMS; b++) begin
        p = 0;
        for (int s = 0; s < NSAMP; s++) begin
          a = 0;
          for (int ch = 0; ch < NCHAN; ch++) begin
            if (u[ch + NCHAN*b]) begin
              c = int'(data[NBITS*(s + NSAMP*(ch + NCHAN*b)) +: NBITS]);
              if (iv[ch + NCHAN*b]) c = 31 - c;
              a += 2*c - 31;
            end
          end
          hSum[0][b*NSAMP+s] = a;
          hSq[0][b*NSAMP+s] = a * a;
          p += a * a;
        end
        mAcc[b] = (mCnt == 0 ? 0 : mAcc[b]) + p;
        hTot[0][b] = int'(mAcc[b]);
      end
      hLast[0] = (mCnt == ACCLEN - 1);
      mCnt = (mCnt + 1) % ACCLEN;
    end
    @(posedge clk); #1;
    eSqV = hVld[2];
    if (hVld[2])
      for (int i = 0; i < NS; i++) begin
        eSum[i] = hSum[2][i]; eSq[i] = hSq[2][i];
      end
    eAccV = hVld[3] && hLast[3];
    if (eAccV)
      for (int b = 0; b < NBEAMS; b++) eAcc[b] = hTot[3][b];
    if (accValid === 1'b1) accPulses++;
    checkAll("cyc");
  endtask

  task automatic doReset();
    valid = 0; cfgUpd = 0;
    #2 rst = 1;
    #1;
    modelReset();
    checkAll("rst");
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic fillAll(input int code);
    for (int i = 0; i < NT; i++) data[i*NBITS +: NBITS] = NBITS'(code);
  endtask

  typedef struct {
    bit upd;
    int code;
    logic [NB-1:0] u, iv;
    int s0, s1, q0, q1, a0, a1;
  } vec_t;

  vec_t vt[5];
  int q[$];
  int expQ[8];

  initial begin
    vt[0] = '{0, 31, 16'hFFFF, 16'h0000, 248, 248, 61504, 61504,
              984064, 984064};
    vt[1] = '{1, 31, 16'hFFFF, 16'h000F, 0, 248, 0, 61504,
              0, 984064};
    vt[2] = '{1, 0, 16'h0001, 16'h0000, -31, 0, 961, 0, 15376, 0};
    vt[3] = '{1, 16, 16'hFFFF, 16'hFFFF, -8, -8, 64, 64, 1024, 1024};
    vt[4] = '{1, 0, 16'hFFFF, 16'h0000, -248, -248, 61504, 61504,
              984064, 984064};

    #1 rst = 1;
    #2;
    modelReset();
    checkAll("por");
    @(posedge clk); #1;
    rst = 0;

    for (int n = 0; n < 5; n++) begin
      useV = vt[n].u; invV = vt[n].iv;
      if (vt[n].upd) cycle(0, 1);
      fillAll(vt[n].code);
      for (int k = 0; k < ACCLEN; k++) cycle(1, 0);
      for (int k = 0; k < 4; k++) cycle(0, 0);
      chk($sformatf("v%0d.sum0", n), sumAt(0), vt[n].s0);
      chk($sformatf("v%0d.sum1", n), sumAt(NSAMP), vt[n].s1);
      chk($sformatf("v%0d.sq0", n), sqAt(0), vt[n].q0);
      chk($sformatf("v%0d.sq1", n), sqAt(NSAMP), vt[n].q1);
      chk($sformatf("v%0d.acc0", n), accAt(0), vt[n].a0);
      chk($sformatf("v%0d.acc1", n), accAt(1), vt[n].a1);
    end

    // sparse valid pattern: one window closes on the 4th valid beat
    doReset();
    useV = '1; invV = '0;
    accPulses = 0;
    begin
      bit pat[7];
      pat = '{1, 0, 0, 1, 1, 0, 1};
      for (int k = 0; k < 7; k++) begin
        data = {$urandom, $urandom, $urandom, $urandom, $urandom};
        cycle(pat[k], 0);
      end
    end
    for (int k = 0; k < 6; k++) cycle(0, 0);
    chk("pat.pulses", accPulses, 1);

    // config written mid-window only lands on the next window
    doReset();
    fillAll(31);
    useV = '1; invV = '0;
    q.delete();
    cycle(1, 0);
    if (sqValid) q.push_back(int'(sumAt(0)));
    invV = 16'h000F;
    cycle(1, 1);
    if (sqValid) q.push_back(int'(sumAt(0)));
    for (int k = 0; k < 2; k++) begin
      cycle(1, 0);
      if (sqValid) q.push_back(int'(sumAt(0)));
    end
    chk("mid.pend1", longint'(cfgPend), 1);
    cycle(1, 0);
    if (sqValid) q.push_back(int'(sumAt(0)));
    chk("mid.pend0", longint'(cfgPend), 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0);
      if (sqValid) q.push_back(int'(sumAt(0)));
    end
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0);
      if (sqValid) q.push_back(int'(sumAt(0)));
    end
    expQ = '{248, 248, 248, 248, 0, 0, 0, 0};
    chk("mid.count", q.size(), 8);
    for (int k = 0; k < 8 && k < q.size(); k++)
      chk($sformatf("mid.sum%0d", k), q[k], expQ[k]);
    chk("mid.acc0", accAt(0), 0);

    // reset mid-window discards the partial window
    useV = '1; invV = '0;
    cycle(0, 1);
    cycle(1, 0);
    cycle(1, 0);
    doReset();
    accPulses = 0;
    for (int k = 0; k < 3; k++) cycle(1, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0);
    chk("rst.nopulse", accPulses, 0);
    cycle(1, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0);
    chk("rst.pulse", accPulses, 1);
    chk("rst.acc0", accAt(0), 984064);

    // random beats, configs and updates
    doReset();
    for (int k = 0; k < 300; k++) begin
      data = {$urandom, $urandom, $urandom, $urandom, $urandom};
      useV = NB'($urandom);
      invV = NB'($urandom);
      cycle(($urandom % 4) != 0, ($urandom % 12) == 0);
    end
    for (int k = 0; k < 4; k++) cycle(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nErr);
    $finish;
  end
endmodule

// File: doc/param_beamform_square_accum.md
PARAM_BEAMFORM_SQUARE_ACCUM -- requirements
Module: param_beamform_square_accum

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- NBITS, 5, sample width; offset-binary code c.
- NSAMP, 4, samples per clock.
- NCHAN, 8, channels per beam.
- NBEAMS, 2, independent beams.
- ACCLEN, 4, valid beats per integration window; power of 2, at least 2.
REQ-002 Derived widths:
- SW = NBITS+1+clog2(NCHAN)
- SQW = 2*SW-2
- ACCW = SQW+clog2(NSAMP*ACCLEN)
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk_i, in, 1, sole clock.
- rst_i, in, 1, asynchronous active-high reset.
- valid_i, in, 1, data_i beat valid.
- data_i, in, NBEAMS*NCHAN*NSAMP*NBITS, sample (b,ch,s) at bit offset NBITS*(s+NSAMP*(ch+NCHAN*b)).
- use_i, in, NBEAMS*NCHAN, channel enable; bit ch+NCHAN*b.
- invert_i, in, NBEAMS*NCHAN, channel polarity flip; same indexing as use_i.
- cfg_update_i, in, 1, capture use_i/invert_i into shadow.
- cfg_pending_o, out, 1, shadow not yet active.
- sum_o, out, NBEAMS*NSAMP*SW, signed beam sums.
- sq_o, out, NBEAMS*NSAMP*SQW, unsigned squares.
- sq_valid_o, out, 1, sum_o/sq_o valid.
- acc_o, out, NBEAMS*ACCW, window power per beam.
- acc_valid_o, out, 1, one-cycle acc_o strobe.

Function
REQ-004 Each sample maps to odd doubled value v=2*c'-(2^NBITS-1), where c'=~c if inverted, else c.
REQ-005 A disabled channel contributes exactly 0, so the beam sum has no half-LSB offset and the square is an exact integer.
REQ-006 S(b,s) = signed sum of v over the beam's channels; width SW, cannot overflow.
REQ-007 sq = S*S, width SQW, unsigned, exact; no truncation and no correction term.
REQ-008 Pipeline stage 1 registers data_i with active use/invert applied.
REQ-009 Pipeline stage 2 registers S.
REQ-010 Pipeline stage 3 registers sq, plus a copy of S delayed one cycle.
REQ-011 sum_o, sq_o and sq_valid_o appear 3 cycles after the valid_i beat.
REQ-012 valid, window-first and window-last flags travel with the data through all 3 stages.
REQ-013 When a beat is not valid, sum_o and sq_o hold their last values and sq_valid_o=0.
REQ-014 The input window counter advances modulo ACCLEN on valid_i only. Count 0 marks the first beat; count ACCLEN-1 marks the last beat.
REQ-015 Per beam, the accumulator is set to the sum of the NSAMP squares on a first beat and adds that sum on each later valid beat.
REQ-016 On a last beat, acc_o takes the completed total and acc_valid_o pulses high for 1 cycle. This occurs 4 cycles after the last valid_i beat.
REQ-017 acc_o holds its value between pulses.
REQ-018 Accumulator width ACCW; no saturation is needed or permitted.
REQ-019 cfg_update_i=1 captures use_i/invert_i into the shadow registers, and cfg_pending_o goes high on the next cycle.
REQ-020 The shadow is copied to the active configuration on the next valid_i first beat, and that beat already uses the new configuration. cfg_pending_o clears on the following cycle.
REQ-021 If cfg_update_i coincides with a transfer, the old shadow transfers, the new value is captured, and cfg_pending_o stays 1.
REQ-022 Configuration never changes within a window.
REQ-023 Repeated cfg_update_i while pending: last write wins.

Reset
REQ-024 rst_i=1 immediately clears the following to 0: all pipeline registers, counter, accumulators, sum_o, sq_o, acc_o, sq_valid_o, acc_valid_o, cfg_pending_o.
REQ-025 Reset loads active and shadow use = all ones and invert = all zeros.
REQ-026 A partial window is discarded on reset. The first valid beat after release is a window first beat.
REQ-027 Beats in flight at reset produce no outputs.

Verification (NBITS=5, NCHAN=8, NSAMP=4, NBEAMS=2, ACCLEN=4; SW=9, SQW=16, ACCW=20)
REQ-028 Stimulus: all codes 31, defaults, 4 valid beats -> per sample: sum_o=248, sq_o=61504. acc_o=984064 per beam, with acc_valid_o 4 cycles after the last beat.
REQ-029 Stimulus: all codes 31; beam 0 invert ch0-3, applied via update -> beam 0 sum_o=0, sq_o=0, acc_o=0; beam 1 unchanged at 61504 per sample.
REQ-030 Stimulus: use only ch0 of beam 0, code 0 -> sum_o=-31 (9'h1E1), sq_o=961, acc_o=15376.
REQ-031 Stimulus: cfg_update_i on the 2nd beat of a window -> cfg_pending_o=1 until the next first beat; the old configuration holds for the rest of the current window, and sums change exactly at the first beat of the next window.
REQ-032 Stimulus: valid_i pattern 1,0,0,1,1,0,1 -> sq_valid_o mirrors the pattern delayed 3 cycles; a single acc_valid_o follows the 4th valid beat.
REQ-033 Stimulus: rst_i pulsed after 2 beats of a window -> all outputs 0 asynchronously; the next acc_valid_o requires 4 fresh valid beats.
